// File: rtl/mesh_inj_pkg.sv
// Shared definitions for the mesh terminal injection arbiter: packet field
// widths, payload width helper and the injection FSM state encoding.
package mesh_inj_pkg;

  localparam int NXTJP_W = 8;
  localparam int ROW_W   = 4;
  localparam int COL_W   = 4;
  localparam int MODE_W  = 1;
  localparam int HDR_W   = NXTJP_W + ROW_W + COL_W + MODE_W;

  // Payload bits left below the routing header for a given packet width
  function automatic int payload_w(input int pkt_w);
    return pkt_w - HDR_W;
  endfunction

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } inj_state_t;

endpackage

// File: rtl/mesh_term_inj_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request found while walking
// upward from ptr, wrapping N-1 -> 0. Purely combinational.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found_s;
  logic [IW-1:0] idx_s;

  // Rotating priority search; the first hit from ptr upward wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      idx_s = IW'((int'(ptr) + i) % N);
      if (!found_s && req[idx_s]) begin
        found_s    = 1'b1;
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mesh_term_inj_arb.sv
// Injection arbiter for one mesh terminal: shares the terminal input port
// among NREQ packet sources round-robin, holds each presented packet until
// the router pops it, and flags stalls and spurious pops.
module mesh_term_inj_arb
  import mesh_inj_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int pckg_sz = 20,
  parameter int TIMEOUT = 64,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*pckg_sz-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    pndng_i_in,
  output logic [pckg_sz-1:0]      data_out_i_in,
  input  logic                    popin,
  output logic [IW-1:0]           grant_id,
  output logic [15:0]             pkt_cnt,
  output logic                    stall_err,
  output logic                    proto_err
);

  // Wide enough to hold TIMEOUT-1 with headroom for saturation
  localparam int SW = $clog2(TIMEOUT) + 1;

  inj_state_t         state_r;
  inj_state_t         state_nxt_s;
  logic [IW-1:0]      rr_ptr_r;
  logic [IW-1:0]      rr_ptr_nxt_s;
  logic [SW-1:0]      stall_cnt_r;
  logic [NREQ-1:0]    gnt_s;
  logic [IW-1:0]      gnt_idx_s;
  logic [pckg_sz-1:0] sel_data_s;
  logic               load_s;
  logic               waiting_s;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign pndng_i_in = (state_r == PRESENT);
  assign waiting_s  = (state_r == PRESENT) && !popin;

  // Pick the winner's packet out of the flat request bus (grant is one-hot)
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_data_s = sel_data_s | (req_data[i*pckg_sz +: pckg_sz] & {pckg_sz{gnt_s[i]}});
    end
  end

  // Next pointer: one past the winner, wrapping at NREQ
  always_comb begin
    if (gnt_idx_s == IW'(NREQ - 1)) begin
      rr_ptr_nxt_s = '0;
    end else begin
      rr_ptr_nxt_s = gnt_idx_s + IW'(1);
    end
  end

  // FSM next state, load decision and the handshake toward requesters
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    req_ready   = '0;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          load_s      = 1'b1;
          state_nxt_s = PRESENT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESENT: begin
        if (popin && (|req_valid)) begin
          load_s      = 1'b1;
          state_nxt_s = PRESENT;
        end else if (popin) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PRESENT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (reset) begin
      load_s      = 1'b0;
      state_nxt_s = IDLE;
    end else begin
      load_s = load_s;
    end
    if (load_s) begin
      req_ready = gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  // State, presented packet, round-robin pointer, counters and sticky errors
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      rr_ptr_r      <= '0;
      data_out_i_in <= '0;
      grant_id      <= '0;
      pkt_cnt       <= 16'd0;
      stall_cnt_r   <= '0;
      stall_err     <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        data_out_i_in <= sel_data_s;
        grant_id      <= gnt_idx_s;
        rr_ptr_r      <= rr_ptr_nxt_s;
      end
      if ((state_r == PRESENT) && popin) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if ((state_r == IDLE) && popin) begin
        proto_err <= 1'b1;
      end
      if (load_s || popin) begin
        stall_cnt_r <= '0;
      end else if (waiting_s && (stall_cnt_r != {SW{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + SW'(1);
      end
      if (waiting_s && (stall_cnt_r >= SW'(TIMEOUT - 1))) begin
        stall_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mesh_term_inj_arb.sv
// Directed, table-driven bench for mesh_term_inj_arb (NREQ=4, 20-bit packets,
// TIMEOUT=4) plus a hand-written packet-counter wrap sequence.
module tb_mesh_term_inj_arb;

  localparam int NREQ = 4;
  localparam int PW   = 20;

  localparam logic [19:0] R0 = 20'h10A00;
  localparam logic [19:0] R1 = 20'h00257;
  localparam logic [19:0] R2 = 20'h20B33;
  localparam logic [19:0] R3 = 20'h3FC44;

  logic             clk;
  logic             reset;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*PW-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             pndng_i_in;
  logic [PW-1:0]    data_out_i_in;
  logic             popin;
  logic [1:0]       grant_id;
  logic [15:0]      pkt_cnt;
  logic             stall_err;
  logic             proto_err;

  int n_checks = 0;
  int n_errors = 0;

  mesh_term_inj_arb #(.NREQ(NREQ), .pckg_sz(PW), .TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .popin         (popin),
    .grant_id      (grant_id),
    .pkt_cnt       (pkt_cnt),
    .stall_err     (stall_err),
    .proto_err     (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic        pop;
    logic [3:0]  rdy;
    logic        pnd;
    logic [19:0] dat;
    logic [1:0]  gid;
    logic [15:0] cnt;
    logic        st;
    logic        pr;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (vector %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] valid, input logic pop,
                     input logic [3:0] rdy, input logic pnd, input logic [19:0] dat,
                     input logic [1:0] gid, input logic [15:0] cnt, input logic st,
                     input logic pr);
    vec_t v;
    v.rst = rst; v.valid = valid; v.pop = pop; v.rdy = rdy; v.pnd = pnd;
    v.dat = dat; v.gid = gid; v.cnt = cnt; v.st = st; v.pr = pr;
    tv.push_back(v);
  endtask

  initial begin
    req_data  = {R3, R2, R1, R0};
    reset     = 1'b1;
    req_valid = 4'b0000;
    popin     = 1'b0;

    // Reset, then single packet from requester 1
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 20'h0, 2'd0, 16'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 20'h0, 2'd0, 16'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 20'h0, 2'd0, 16'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, R1,    2'd1, 16'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, R1,    2'd1, 16'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, R1,    2'd1, 16'd1, 1'b0, 1'b0);
    // Reset so fairness starts at requester 0; all valid, pop every cycle
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, R1,    2'd1, 16'd1, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 20'h0, 2'd0, 16'd0, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, R0,    2'd0, 16'd0, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, R1,    2'd1, 16'd1, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, R2,    2'd2, 16'd2, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, R3,    2'd3, 16'd3, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, R0,    2'd0, 16'd4, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, R1,    2'd1, 16'd5, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, R2,    2'd2, 16'd6, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, R3,    2'd3, 16'd7, 1'b0, 1'b0);
    // Hold R0 with no pop for 10 presented cycles; error from the 5th
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, R0,    2'd0, 16'd8, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, R0,    2'd0, 16'd8, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, R0,    2'd0, 16'd8, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, R0,    2'd0, 16'd8, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, R0,    2'd0, 16'd8, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      add(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, R0,  2'd0, 16'd8, 1'b1, 1'b0);
    end
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, R0,    2'd0, 16'd8, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, R0,    2'd0, 16'd9, 1'b1, 1'b0);
    // Pop while idle
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, R0,    2'd0, 16'd9, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, R0,    2'd0, 16'd9, 1'b1, 1'b1);
    // Reset mid-PRESENT together with a pop, then restart at requester 0
    add(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0, R0,    2'd0, 16'd9, 1'b1, 1'b1);
    add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, R1,    2'd1, 16'd9, 1'b1, 1'b1);
    add(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, R1,    2'd1, 16'd9, 1'b1, 1'b1);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 20'h0, 2'd0, 16'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, R0,    2'd0, 16'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, R0,    2'd0, 16'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, R0,    2'd0, 16'd1, 1'b0, 1'b0);

    // Initial reset: two clock edges with reset high
    @(posedge clk); #1;
    @(posedge clk); #1;

    foreach (tv[k]) begin
      reset     = tv[k].rst;
      req_valid = tv[k].valid;
      popin     = tv[k].pop;
      #1;
      check("req_ready",  k, 32'(req_ready),     32'(tv[k].rdy));
      check("pndng",      k, 32'(pndng_i_in),    32'(tv[k].pnd));
      check("data_out",   k, 32'(data_out_i_in), 32'(tv[k].dat));
      check("grant_id",   k, 32'(grant_id),      32'(tv[k].gid));
      check("pkt_cnt",    k, 32'(pkt_cnt),       32'(tv[k].cnt));
      check("stall_err",  k, 32'(stall_err),     32'(tv[k].st));
      check("proto_err",  k, 32'(proto_err),     32'(tv[k].pr));
      @(posedge clk); #1;
    end

    // Counter wrap: one requester, pop every cycle for 65536 deliveries
    reset     = 1'b1;
    req_valid = 4'b0001;
    popin     = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    popin = 1'b1;
    for (int c = 0; c < 65535; c++) begin
      @(posedge clk);
    end
    #1;
    check("wrap_ffff",  -1, 32'(pkt_cnt),    32'h0000FFFF);
    check("wrap_pndng", -1, 32'(pndng_i_in), 32'd1);
    @(posedge clk); #1;
    check("wrap_zero",  -1, 32'(pkt_cnt),    32'd0);
    popin     = 1'b0;
    req_valid = 4'b0000;
    @(posedge clk); #1;
    check("wrap_hold",  -1, 32'(pkt_cnt),    32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mesh_term_inj_arb.md
# mesh_term_inj_arb

Injection arbiter for one terminal of the `mesh_gnrtr` router mesh. It shares the terminal's input port (`pndng_i_in` / `data_out_i_in` / `popin`) among NREQ packet sources using round-robin arbitration. It holds each granted packet stable until the router pops it, and reports stall and protocol errors. It sits between test agents or traffic generators and the mesh terminal.

## Interface
- `NREQ`, default 4: number of requesters (≥2).
- `pckg_sz`, default 20: packet width. Layout from MSB down: Nxtjp[8], row[4], colum[4], mode[1], payload[pckg_sz-17].
- `TIMEOUT`, default 64: cycles a packet may stay presented without `popin` before `stall_err` is raised.
- `clk`, in, 1: clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NREQ: requester i has a packet.
- `req_data`, in, NREQ*pckg_sz: packet of requester i in bits [i*pckg_sz +: pckg_sz].
- `req_ready`, out, NREQ: one-hot accept. The transfer happens on a cycle where `req_valid[i] && req_ready[i]`.
- `pndng_i_in`, out, 1: packet pending toward the router terminal.
- `data_out_i_in`, out, pckg_sz: presented packet, registered.
- `popin`, in, 1: router consumed the presented packet (one-cycle pulse).
- `grant_id`, out, $clog2(NREQ): source index of the presented packet.
- `pkt_cnt`, out, 16: packets delivered (popins accepted); wraps 0xFFFF→0.
- `stall_err`, out, 1: sticky; timeout expired.
- `proto_err`, out, 1: sticky; `popin` seen while nothing pending.

## Operation
- States: IDLE (nothing presented) and PRESENT (`pndng_i_in`=1).
- `load` = any `req_valid` && (state==IDLE || `popin`).
- Winner: first set `req_valid` bit, searching from `rr_ptr` upward with wrap NREQ-1→0.
- `req_ready[winner]` = `load`, combinational from `req_valid`, state, `popin` and `rr_ptr`. All other bits are 0. All bits are 0 while `reset`=1.
- On `load`:
  - latch the winner's data into `data_out_i_in` and the winner's index into `grant_id`;
  - `rr_ptr` ← winner+1, mod NREQ;
  - next state is PRESENT.
- PRESENT with `popin` and no valid requester: `pkt_cnt`+1, next state IDLE. `data_out_i_in` and `grant_id` keep their last values.
- PRESENT with `popin` and `load`: `pkt_cnt`+1 and the next packet is loaded in the same cycle. This is back-to-back delivery with no idle cycle.
- PRESENT without `popin`:
  - outputs are held bit-stable;
  - `stall_cnt`+1, saturating;
  - when `stall_cnt` reaches TIMEOUT-1 while still waiting, `stall_err` ← 1 the next cycle;
  - the packet is never dropped.
- `stall_cnt` clears on every load and every `popin`.
- IDLE with `popin`: `proto_err` ← 1. There is no other effect and `pkt_cnt` is unchanged.
- A requester that drops `req_valid` before it is granted loses nothing; only handshaked packets are taken.

## Timing
- Reset values: `pndng_i_in`=0, `data_out_i_in`=0, `grant_id`=0, `pkt_cnt`=0, `stall_err`=0, `proto_err`=0, `req_ready`=0, `rr_ptr`=0, `stall_cnt`=0, state IDLE.
- Latency: a handshake in cycle N gives `pndng_i_in`=1 with the data in cycle N+1.
- `popin` in cycle M gives either `pndng_i_in`=0 in M+1, or new data in M+1 if a load happened in M.
- Throughput: one packet per cycle when the router pops every cycle.
- Reset mid-PRESENT: the packet is discarded and all state returns to reset values in the next cycle.
- `popin` and `reset` in the same cycle: reset wins and `pkt_cnt` stays 0.
- Sticky errors clear only on reset.

## Structure
- Package `mesh_inj_pkg` holds:
  - field widths and offsets (NXTJP_W=8, ROW_W=4, COL_W=4, MODE_W=1) and the payload-width function of `pckg_sz`;
  - the state enum `inj_state_t` {IDLE, PRESENT}.
- Sub-module `rr_arbiter`, parameter N:
  - inputs `req`[N], `ptr`;
  - outputs one-hot `gnt` and `gnt_idx`;
  - purely combinational.
- The top level holds the state register, data/grant registers, counters and error flags.

## Test plan
- Single packet: after reset, requester 1 sends 20'h00257 ({Nxtjp=0, row=2, colum=5, mode=0, payload=7}) → `req_ready`=4'b0010 that cycle; next cycle `pndng_i_in`=1, `data_out_i_in`=20'h00257, `grant_id`=1. Then `popin` → `pndng_i_in`=0 and `pkt_cnt`=1.
- Fairness: all four requesters valid continuously, `popin` every cycle → grant order 0,1,2,3,0,1… and 8 packets in 8 consecutive cycles after the first.
- Hold and timeout with TIMEOUT=4: no `popin` for 10 cycles → data stays stable and `stall_err`=1 from the 5th presented cycle. A later `popin` delivers the packet and `stall_err` stays 1.
- Protocol error: `popin` in IDLE → `proto_err`=1 and `pkt_cnt` unchanged.
- Reset mid-operation: `reset` asserted while PRESENT with requesters still valid → next cycle all outputs are at reset values. After reset is released, arbitration restarts at requester 0.
- Counter wrap: force 65536 deliveries → `pkt_cnt` returns to 0.
